// File: rtl/seq_stream_ctrl_pkg.sv
// Shared definitions for the serial stream controller slice.
// Holds the controller FSM state type and the default frame/counter sizes.
package seq_stream_ctrl_pkg;

   localparam int FRAME_LEN_DEF = 24;
   localparam int CNT_W_DEF     = 5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/seq_stream_ctrl_shifter.sv
// Parallel-load, MSB-first serializer.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the register
//   load  - capture din (takes priority over shift)
//   shift - shift left by one, zero fill
//   din   - parallel word
//   sout  - current MSB
module seq_shifter
   import seq_stream_ctrl_pkg::*;
#(
   parameter int WIDTH = FRAME_LEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             sout
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= {sr[WIDTH-2:0], 1'b0};
      end
   end

   assign sout = sr[WIDTH-1];

endmodule

// File: rtl/seq_stream_ctrl.sv
// Two-requester frame arbiter feeding a serial sequence detector.
// A granted frame word is serialized MSB-first; the detector's registered
// match flag is counted over the frame's bits and reported in hits.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req0/data0          - requester 0 frame request and word
//   req1/data1          - requester 1 frame request and word
//   gnt0/gnt1           - one-cycle grant pulses (LOAD cycle)
//   x                   - serial bit to detector (0 outside SHIFT)
//   z                   - detector match flag (one cycle behind x)
//   det_clr             - detector clear
//   busy, done          - not-IDLE flag, one-cycle frame-complete pulse
//   owner, hits         - requester and match count of current/last frame
module seq_stream_ctrl
   import seq_stream_ctrl_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0,
   input  logic [FRAME_LEN-1:0] data0,
   input  logic                 req1,
   input  logic [FRAME_LEN-1:0] data1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 x,
   input  logic                 z,
   output logic                 det_clr,
   output logic                 busy,
   output logic                 done,
   output logic                 owner,
   output logic [CNT_W-1:0]     hits
);

   localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   state_t         state, state_nxt;
   logic [BW-1:0]  bit_cnt;
   logic           last;
   logic           win;
   logic           any_req;
   logic           load;
   logic           shift_en;
   logic           sample;
   logic           sout;

   always_comb begin
      any_req   = req0 | req1;
      // with both requesting, the one not served last wins
      win       = (req0 && req1) ? ~last : req1;
      load      = (state == IDLE) && any_req;
      shift_en  = (state == SHIFT);
      // z trails x by one cycle: skip the first SHIFT cycle, include DRAIN
      sample    = ((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN);

      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (bit_cnt == BW'(FRAME_LEN - 1)) state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         last    <= 1'b1;
         owner   <= 1'b0;
         hits    <= '0;
         det_clr <= 1'b1;
      end else begin
         state   <= state_nxt;
         det_clr <= (state_nxt == LOAD);
         if (load) begin
            owner <= win;
            last  <= win;
            hits  <= '0;
         end else if (sample && z && (hits != '1)) begin
            hits  <= hits + CNT_W'(1);
         end
         if (state == LOAD) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + BW'(1);
         end
      end
   end

   seq_shifter #(
      .WIDTH (FRAME_LEN)
   ) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .shift (shift_en),
      .din   (win ? data1 : data0),
      .sout  (sout)
   );

   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign gnt0 = (state == LOAD) && !owner;
   assign gnt1 = (state == LOAD) && owner;
   assign x    = shift_en & sout;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
module tb_seq_stream_ctrl;

   localparam int N    = 24;
   localparam int CW   = 5;
   localparam int HMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, req0, req1, z;
   logic [N-1:0]  data0, data1;
   logic          gnt0, gnt1, x, det_clr, busy, done, owner;
   logic [CW-1:0] hits;

   seq_stream_ctrl #(.FRAME_LEN(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .gnt0(gnt0), .gnt1(gnt1), .x(x), .z(z), .det_clr(det_clr), .busy(busy),
      .done(done), .owner(owner), .hits(hits)
   );

   // small instance to reach counter saturation
   logic       s_rst, s_req0, s_req1, s_z;
   logic [5:0] s_data0, s_data1;
   logic       s_gnt0, s_gnt1, s_x, s_det_clr, s_busy, s_done, s_owner;
   logic [1:0] s_hits;

   seq_stream_ctrl #(.FRAME_LEN(6), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(s_rst), .req0(s_req0), .data0(s_data0), .req1(s_req1), .data1(s_data1),
      .gnt0(s_gnt0), .gnt1(s_gnt1), .x(s_x), .z(s_z), .det_clr(s_det_clr), .busy(s_busy),
      .done(s_done), .owner(s_owner), .hits(s_hits)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a frame is tracked by its cycle offset k from the grant.
   bit         m_active;
   int         m_k;
   bit         m_owner, m_last, m_post_rst;
   logic [N-1:0] m_data;
   int         m_hits;

   task automatic model_edge();
      if (rst) begin
         m_active = 0; m_k = 0; m_hits = 0; m_owner = 0; m_last = 1; m_post_rst = 1;
      end else begin
         m_post_rst = 0;
         if (m_active) begin
            if (z && m_k >= 2 && m_k <= N + 1 && m_hits < HMAX) m_hits++;
            if (m_k == N + 2) m_active = 0;
            else m_k++;
         end else if (req0 || req1) begin
            m_owner  = (req0 && req1) ? !m_last : req1;
            m_last   = m_owner;
            m_data   = m_owner ? data1 : data0;
            m_hits   = 0;
            m_active = 1;
            m_k      = 0;
         end
      end
   endtask

   task automatic step();
      bit ex;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      ex = 0;
      if (m_active && m_k >= 1 && m_k <= N) ex = m_data[N - m_k];
      check_eq("busy",    32'(busy),    32'(m_active));
      check_eq("gnt0",    32'(gnt0),    32'(m_active && m_k == 0 && !m_owner));
      check_eq("gnt1",    32'(gnt1),    32'(m_active && m_k == 0 && m_owner));
      check_eq("det_clr", 32'(det_clr), 32'(m_post_rst || (m_active && m_k == 0)));
      check_eq("x",       32'(x),       32'(ex));
      check_eq("done",    32'(done),    32'(m_active && m_k == N + 2));
      check_eq("hits",    32'(hits),    32'(m_hits));
      check_eq("owner",   32'(owner),   32'(m_owner));
   endtask

   // which: 0 gnt0, 1 gnt1, 2 done
   task automatic wait_for(input int which);
      for (int i = 0; i < 64; i++) begin
         step();
         if ((which == 0 && gnt0) || (which == 1 && gnt1) || (which == 2 && done)) return;
      end
      check_eq("wait_timeout", 32'(which), 32'hFFFF);
   endtask

   initial begin
      logic [N-1:0] xs;
      bit o1, saw_done;
      int gap;

      rst = 1; req0 = 0; req1 = 0; z = 0; data0 = '0; data1 = '0;
      s_rst = 1; s_req0 = 0; s_req1 = 0; s_z = 1; s_data0 = 6'h2A; s_data1 = '0;
      m_active = 0; m_k = 0; m_hits = 0; m_owner = 0; m_last = 1; m_post_rst = 1;
      step(); step();
      rst = 0;

      // single frame, z low
      req0 = 1; data0 = 24'h0C9094;
      wait_for(0);
      req0 = 0; data0 = '0;
      xs = '0;
      for (int i = 0; i < N; i++) begin
         step();
         xs = {xs[N-2:0], x};
      end
      check_eq("x_seq", 32'(xs), 32'h0C9094);
      step(); step();
      check_eq("done_at_g26", 32'(done), 32'd1);
      check_eq("owner_a", 32'(owner), 32'd0);
      check_eq("hits_z0", 32'(hits), 32'd0);
      step();

      // z tied high
      z = 1; req1 = 1; data1 = N'($urandom);
      wait_for(1);
      req1 = 0;
      wait_for(2);
      check_eq("hits_z1", 32'(hits), 32'd24);
      z = 0;
      step();

      // simultaneous requests from reset
      rst = 1; step(); rst = 0;
      req0 = 1; req1 = 1; data0 = N'($urandom); data1 = N'($urandom);
      wait_for(0);
      req0 = 0;
      wait_for(2);
      o1 = owner;
      wait_for(1);
      req1 = 0;
      wait_for(2);
      check_eq("owner_seq0", 32'(o1), 32'd0);
      check_eq("owner_seq1", 32'(owner), 32'd1);
      step();

      // back-to-back from req1 alone
      req1 = 1; data1 = N'($urandom);
      wait_for(1);
      wait_for(2);
      gap = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!busy) gap++;
         else break;
      end
      check_eq("b2b_gap", 32'(gap), 32'd1);
      check_eq("b2b_gnt1", 32'(gnt1), 32'd1);
      req1 = 0;
      wait_for(2);
      step();

      // reset mid-frame at G+10
      z = 1; req0 = 1; data0 = N'($urandom);
      wait_for(0);
      req0 = 0;
      for (int i = 0; i < 10; i++) step();
      rst = 1;
      step();
      check_eq("abort_x", 32'(x), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_det_clr", 32'(det_clr), 32'd1);
      check_eq("abort_hits", 32'(hits), 32'd0);
      rst = 0; z = 0;
      saw_done = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) saw_done = 1;
      end
      check_eq("abort_no_done", 32'(saw_done), 32'd0);
      req0 = 1; req1 = 1;
      step();
      check_eq("abort_prio_gnt0", 32'(gnt0), 32'd1);
      req0 = 0;
      wait_for(2);
      wait_for(1);
      req1 = 0;
      wait_for(2);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         req0  = ($urandom_range(0, 3) != 0);
         req1  = ($urandom_range(0, 2) == 0);
         data0 = N'($urandom);
         data1 = N'($urandom);
         z     = 1'($urandom);
         rst   = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 0; req0 = 0; req1 = 0; z = 0;

      // counter saturation on the small instance
      step();
      s_rst = 0; s_req0 = 1;
      saw_done = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (s_gnt0) s_req0 = 0;
         if (s_done) begin
            saw_done = 1;
            break;
         end
      end
      check_eq("sat_done_seen", 32'(saw_done), 32'd1);
      check_eq("sat_hits", 32'(s_hits), 32'd3);
      check_eq("sat_busy", 32'(s_busy), 32'd1);
      step();
      check_eq("sat_hold", 32'(s_hits), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
